// File: rtl/cache_pkg.sv
// Shared width helpers and controller state encoding for the cache set.
package cache_pkg;

    typedef enum logic {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } state_t;

    localparam int DATA_W = 32;

    function automatic int clog2i(input int value);
        int result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) result = i + 1;
        end
        return result;
    endfunction

    function automatic int idx_width(input int lines);
        return clog2i(lines);
    endfunction

    function automatic int off_width(input int words_per_block);
        return clog2i(words_per_block);
    endfunction

    function automatic int tag_width(input int lines, input int words_per_block);
        return 32 - idx_width(lines) - off_width(words_per_block) - 2;
    endfunction

    function automatic int way_width(input int ways);
        return clog2i(ways);
    endfunction

endpackage

// File: rtl/simple_ram.sv
// Single-port RAM with registered read (read-first on a same-address write).
module simple_ram #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4096
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] dout_reg;

    always_ff @(posedge clk) begin
        if (we) mem[addr] <= din;
        dout_reg <= mem[addr];
    end

    assign dout = dout_reg;

endmodule

// File: rtl/cache_set.sv
// N-way set-associative cache set: tag/valid/dirty/round-robin metadata plus per-way data RAM.
// Optional macro CACHE_SET_DIRTY_EN enables dirty-bit storage; without it victim_dirty is 0.
module cache_set
    import cache_pkg::*;
#(
    parameter int  WAYS            = 2,
    parameter int  LINES           = 128,
    parameter int  WORDS_PER_BLOCK = 32,
    localparam int TAG_LENGTH      = tag_width(LINES, WORDS_PER_BLOCK),
    localparam int WAY_W           = way_width(WAYS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [31:0]           a,
    input  logic [31:0]           d,
    input  logic                  we,
    input  logic                  fill_we,
    input  logic [WAY_W-1:0]      fill_way,
    input  logic                  tag_we,
    input  logic                  inval,
    output logic [31:0]           spo,
    output logic                  hit,
    output logic [WAY_W-1:0]      hit_way,
    output logic [WAY_W-1:0]      victim_way,
    output logic [TAG_LENGTH-1:0] victim_tag,
    output logic                  victim_dirty,
    output logic                  init_done
);

    localparam int IDX_W  = idx_width(LINES);
    localparam int OFF_W  = off_width(WORDS_PER_BLOCK);
    localparam int ADDR_W = IDX_W + OFF_W;
    localparam int DEPTH  = LINES * WORDS_PER_BLOCK;

    logic [OFF_W-1:0]      offset;
    logic [IDX_W-1:0]      index;
    logic [TAG_LENGTH-1:0] tag;
    logic                  unused_bits;

    assign offset      = a[OFF_W+1:2];
    assign index       = a[OFF_W+2 +: IDX_W];
    assign tag         = a[31 -: TAG_LENGTH];
    assign unused_bits = ^a[1:0];

    state_t           state_reg, state_next;
    logic [IDX_W-1:0] sweep_reg, sweep_next;
    logic             ready;
    logic             access;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_INIT;
            sweep_reg <= '0;
        end else begin
            state_reg <= state_next;
            sweep_reg <= sweep_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        sweep_next = sweep_reg;
        case (state_reg)
            ST_INIT: begin
                sweep_next = sweep_reg + IDX_W'(1);
                if (sweep_reg == IDX_W'(LINES - 1)) state_next = ST_READY;
            end
            ST_READY: state_next = ST_READY;
            default:  state_next = ST_INIT;
        endcase
    end

    assign ready     = (state_reg == ST_READY);
    assign access    = ready & en;
    assign init_done = ready;

    // Metadata lives in distributed RAM, read combinationally by index.
    logic [TAG_LENGTH-1:0] tag_mem   [WAYS][LINES];
    logic                  valid_mem [WAYS][LINES];
    logic [WAY_W-1:0]      ptr_mem   [LINES];

    logic [WAYS-1:0]  match;
    logic             hit_any;
    logic [WAY_W-1:0] hit_way_c;
    logic [WAY_W-1:0] victim_way_c;
    logic             invalid_found;

    for (genvar gi = 0; gi < WAYS; gi++) begin : g_match
        assign match[gi] = valid_mem[gi][index] && (tag_mem[gi][index] == tag);
    end

    // Descending scan so that multiple matches settle on the lowest way.
    always_comb begin
        hit_any   = 1'b0;
        hit_way_c = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (match[w]) begin
                hit_any   = 1'b1;
                hit_way_c = WAY_W'(w);
            end
        end
    end

    always_comb begin
        victim_way_c  = ptr_mem[index];
        invalid_found = 1'b0;
        for (int w = 0; w < WAYS; w++) begin
            if (!valid_mem[w][index] && !invalid_found) begin
                invalid_found = 1'b1;
                victim_way_c  = WAY_W'(w);
            end
        end
    end

    assign hit        = ready & hit_any;
    assign hit_way    = hit ? hit_way_c : '0;
    assign victim_way = victim_way_c;
    assign victim_tag = tag_mem[victim_way_c][index];

    always_ff @(posedge clk) begin
        if (!ready) begin
            for (int w = 0; w < WAYS; w++) valid_mem[w][sweep_reg] <= 1'b0;
            ptr_mem[sweep_reg] <= '0;
        end else if (access) begin
            for (int w = 0; w < WAYS; w++) begin
                if (tag_we && (fill_way == WAY_W'(w))) begin
                    tag_mem[w][index]   <= tag;
                    valid_mem[w][index] <= 1'b1;
                end else if (inval) begin
                    valid_mem[w][index] <= 1'b0;
                end
            end
            if (tag_we) ptr_mem[index] <= ptr_mem[index] + WAY_W'(1);
        end
    end

`ifdef CACHE_SET_DIRTY_EN
    logic dirty_mem [WAYS][LINES];

    // Invalidation also clears dirty so an invalid victim never reports a writeback.
    always_ff @(posedge clk) begin
        if (!ready) begin
            for (int w = 0; w < WAYS; w++) dirty_mem[w][sweep_reg] <= 1'b0;
        end else if (access) begin
            for (int w = 0; w < WAYS; w++) begin
                if (tag_we && (fill_way == WAY_W'(w))) begin
                    dirty_mem[w][index] <= 1'b0;
                end else if (inval) begin
                    dirty_mem[w][index] <= 1'b0;
                end else if (we && hit_any && (hit_way_c == WAY_W'(w))) begin
                    dirty_mem[w][index] <= 1'b1;
                end
            end
        end
    end

    assign victim_dirty = dirty_mem[victim_way_c][index];
`else
    assign victim_dirty = 1'b0;
`endif

    logic [ADDR_W-1:0] ram_addr;
    logic [WAYS-1:0]   ram_we;
    logic [31:0]       ram_dout [WAYS];

    assign ram_addr = {index, offset};

    for (genvar gi = 0; gi < WAYS; gi++) begin : g_way
        assign ram_we[gi] = access & ((we & hit_any & (hit_way_c == WAY_W'(gi))) |
                                      (fill_we & (fill_way == WAY_W'(gi))));

        simple_ram #(
            .WIDTH (DATA_W),
            .DEPTH (DEPTH)
        ) u_ram (
            .clk  (clk),
            .we   (ram_we[gi]),
            .addr (ram_addr),
            .din  (d),
            .dout (ram_dout[gi])
        );
    end

    // spo follows the RAM for one cycle after a hit access, then holds.
    logic             rd_pending_reg;
    logic [WAY_W-1:0] rd_way_reg;
    logic [31:0]      spo_hold_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_pending_reg <= 1'b0;
            rd_way_reg     <= '0;
            spo_hold_reg   <= '0;
        end else begin
            rd_pending_reg <= en & hit;
            rd_way_reg     <= hit_way_c;
            spo_hold_reg   <= spo;
        end
    end

    assign spo = rd_pending_reg ? ram_dout[rd_way_reg] : spo_hold_reg;

endmodule

// File: tb/tb_cache_set.sv
// Randomized scoreboard bench for cache_set against a set-level behavioural model.
module tb_cache_set;

    localparam int WAYS  = 2;
    localparam int LINES = 128;
    localparam int WPB   = 32;
    localparam int TAG_W = 18;
`ifdef CACHE_SET_DIRTY_EN
    localparam bit DIRTY_ON = 1'b1;
`else
    localparam bit DIRTY_ON = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             en = 1'b0;
    logic [31:0]      a = '0;
    logic [31:0]      d = '0;
    logic             we = 1'b0;
    logic             fill_we = 1'b0;
    logic [0:0]       fill_way = '0;
    logic             tag_we = 1'b0;
    logic             inval = 1'b0;
    logic [31:0]      spo;
    logic             hit;
    logic [0:0]       hit_way;
    logic [0:0]       victim_way;
    logic [TAG_W-1:0] victim_tag;
    logic             victim_dirty;
    logic             init_done;

    always #5 clk = ~clk;

    cache_set #(
        .WAYS            (WAYS),
        .LINES           (LINES),
        .WORDS_PER_BLOCK (WPB)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .a            (a),
        .d            (d),
        .we           (we),
        .fill_we      (fill_we),
        .fill_way     (fill_way),
        .tag_we       (tag_we),
        .inval        (inval),
        .spo          (spo),
        .hit          (hit),
        .hit_way      (hit_way),
        .victim_way   (victim_way),
        .victim_tag   (victim_tag),
        .victim_dirty (victim_dirty),
        .init_done    (init_done)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int n_txn = 0;

    // Reference model: per-set state and per-way word store.
    bit               m_ready = 1'b0;
    logic [TAG_W-1:0] m_tag   [WAYS][LINES];
    bit               m_valid [WAYS][LINES];
    bit               m_dirty [WAYS][LINES];
    int               m_ptr   [LINES];
    logic [31:0]      m_data  [WAYS][LINES*WPB];
    bit               m_known [WAYS][LINES*WPB];

    logic [31:0] exp_q[$];
    int          tb_kind = 0;  // 0: spo must hold, 1: checked read, 2: spo not predicted

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mk_addr(input int t, input int idx, input int off);
        return (32'(t) << 14) | (32'(idx) << 7) | (32'(off) << 2);
    endfunction

    task automatic m_lookup(input logic [31:0] addr, output bit h, output int hw, output int vw);
        int idx;
        logic [TAG_W-1:0] t;
        idx = int'((addr >> 7) % LINES);
        t   = TAG_W'(addr >> 14);
        h   = 1'b0;
        hw  = 0;
        for (int w = 0; w < WAYS; w++) begin
            if (!h && m_valid[w][idx] && m_tag[w][idx] == t) begin
                h  = 1'b1;
                hw = w;
            end
        end
        vw = m_ptr[idx];
        for (int w = WAYS - 1; w >= 0; w--) if (!m_valid[w][idx]) vw = w;
    endtask

    task automatic do_op(input bit e, input logic [31:0] addr, input logic [31:0] dat,
                         input bit w_in, input bit f_in, input int fw, input bit t_in, input bit inv);
        bit h;
        int hw, vw, idx, word;
        @(negedge clk);
        en = e; a = addr; d = dat; we = w_in; fill_we = f_in; fill_way = 1'(fw);
        tag_we = t_in; inval = inv;
        m_lookup(addr, h, hw, vw);
        idx  = int'((addr >> 7) % LINES);
        word = idx * WPB + int'((addr >> 2) % WPB);
        #1;
        chk("hit", 32'(hit), 32'(m_ready && h));
        chk("hit_way", 32'(hit_way), (m_ready && h) ? 32'(hw) : 32'd0);
        if (m_ready) begin
            chk("victim_way", 32'(victim_way), 32'(vw));
            if (m_valid[vw][idx]) chk("victim_tag", 32'(victim_tag), 32'(m_tag[vw][idx]));
            chk("victim_dirty", 32'(victim_dirty), 32'(DIRTY_ON && m_dirty[vw][idx]));
        end
        if (m_ready && e && h) begin
            if (!w_in && !f_in && m_known[hw][word]) begin
                tb_kind = 1;
                exp_q.push_back(m_data[hw][word]);
            end else begin
                tb_kind = 2;
            end
        end else begin
            tb_kind = 0;
        end
        $display("txn %0d a=%h d=%h en=%0b we=%0b fill=%0b way=%0d tag_we=%0b inval=%0b hit=%0b hit_way=%0d victim=%0d",
                 n_txn, addr, dat, e, w_in, f_in, fw, t_in, inv, hit, hit_way, victim_way);
        n_txn++;
        if (m_ready && e) begin
            if (w_in && h) begin m_data[hw][word] = dat; m_known[hw][word] = 1'b1; end
            if (f_in)      begin m_data[fw][word] = dat; m_known[fw][word] = 1'b1; end
            for (int w = 0; w < WAYS; w++) begin
                if (t_in && w == fw) begin
                    m_tag[w][idx] = TAG_W'(addr >> 14);
                    m_valid[w][idx] = 1'b1;
                    m_dirty[w][idx] = 1'b0;
                end else if (inv) begin
                    m_valid[w][idx] = 1'b0;
                    m_dirty[w][idx] = 1'b0;
                end else if (w_in && h && w == hw) begin
                    m_dirty[w][idx] = 1'b1;
                end
            end
            if (t_in) m_ptr[idx] = (m_ptr[idx] + 1) % WAYS;
        end
    endtask

    task automatic m_clear();
        m_ready = 1'b0;
        for (int w = 0; w < WAYS; w++)
            for (int i = 0; i < LINES; i++) begin
                m_valid[w][i] = 1'b0;
                m_dirty[w][i] = 1'b0;
            end
        for (int i = 0; i < LINES; i++) m_ptr[i] = 0;
    endtask

    // Reset, then count edges until init_done while hammering en to show it is ignored.
    task automatic reset_and_init(input int abort_at);
        int cnt;
        @(negedge clk);
        tb_kind = 0;
        rst = 1'b1;
        en = 1'b0; we = 1'b0; fill_we = 1'b0; tag_we = 1'b0; inval = 1'b0;
        m_clear();
        @(negedge clk);
        rst = 1'b0;
        cnt = 0;
        while (cnt < 400) begin
            en = 1'b1; tag_we = 1'b1; fill_we = 1'b1; a = 32'h0000_1040;
            fill_way = 1'($urandom_range(0, 1)); d = $urandom; we = 1'($urandom_range(0, 1));
            inval = 1'b0;
            #1;
            chk("init_hit", 32'(hit), 32'd0);
            chk("init_done_low", 32'(init_done), 32'd0);
            @(posedge clk);
            cnt++;
            #1;
            if (init_done) break;
            if (cnt == abort_at) begin
                @(negedge clk);
                rst = 1'b1;
                @(negedge clk);
                @(negedge clk);
                rst = 1'b0;
                cnt = 0;
                abort_at = -1;
            end else begin
                @(negedge clk);
            end
        end
        en = 1'b0; tag_we = 1'b0; fill_we = 1'b0; we = 1'b0;
        chk("init_cycles", 32'(cnt), 32'(LINES));
        $display("init sequence: init_done after %0d cycles", cnt);
        m_ready = 1'b1;
    endtask

    initial begin : monitor
        logic [31:0] last_spo;
        logic [31:0] e;
        bit known;
        int k;
        last_spo = '0;
        known = 1'b1;
        forever begin
            @(posedge clk);
            k = tb_kind;
            #1;
            if (rst) begin
                chk("spo_reset", spo, 32'd0);
                last_spo = '0;
                known = 1'b1;
            end else if (k == 1) begin
                if (exp_q.size() == 0) begin
                    chk("spo_queue_empty", 32'd0, 32'd1);
                end else begin
                    e = exp_q.pop_front();
                    chk("spo_read", spo, e);
                    last_spo = e;
                    known = 1'b1;
                end
            end else if (k == 2) begin
                known = 1'b0;
            end else if (known) begin
                chk("spo_hold", spo, last_spo);
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        int seq [3];
        bit r_en;
        int r_op;
        logic [31:0] addr;
        seq[0] = 0; seq[1] = 1; seq[2] = 0;

        m_clear();
        reset_and_init(-1);

        // Install + fill way 1, then read back.
        do_op(1, 32'h0000_1040, 32'hDEAD_BEEF, 0, 1, 1, 1, 0);
        do_op(1, 32'h0000_1040, 32'h0, 0, 0, 0, 0, 0);
        chk("req038_hit", 32'(hit), 32'd1);
        chk("req038_hit_way", 32'(hit_way), 32'd1);

        // Make way 1 the round-robin victim, then dirty it with a write hit.
        do_op(1, 32'h0001_5040, 32'h0, 0, 0, 0, 1, 0);
        do_op(1, 32'h0001_9040, 32'h0, 0, 0, 0, 1, 0);
        do_op(1, 32'h0000_1040, 32'h1234_5678, 1, 0, 0, 0, 0);
        do_op(1, 32'h0000_1040, 32'h0, 0, 0, 0, 0, 0);
        chk("req039_victim_way", 32'(victim_way), 32'd1);
        chk("req039_victim_dirty", 32'(victim_dirty), 32'(DIRTY_ON));

        // Pointer wrap at index 2.
        do_op(1, mk_addr(1, 2, 0), 32'h0, 0, 0, 0, 1, 0);
        do_op(1, mk_addr(2, 2, 0), 32'h0, 0, 0, 1, 1, 0);
        for (int i = 0; i < 3; i++) begin
            do_op(1, mk_addr(3 + i, 2, 1), 32'h0, 0, 0, seq[i], 1, 0);
            chk("req040_victim_seq", 32'(victim_way), 32'(seq[i]));
        end

        // Invalidate index of 0x1040.
        do_op(1, 32'h0000_1040, 32'h0, 0, 0, 0, 0, 1);
        do_op(1, 32'h0000_1040, 32'h0, 0, 0, 0, 0, 0);
        chk("req041_hit", 32'(hit), 32'd0);
        chk("req041_victim_way", 32'(victim_way), 32'd0);

        for (int n = 0; n < 250; n++) begin
            addr = mk_addr($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
            r_en = ($urandom_range(0, 7) != 0);
            r_op = $urandom_range(0, 9);
            case (r_op)
                0, 1, 2, 3: do_op(r_en, addr, $urandom, 0, 0, 0, 0, 0);
                4, 5:       do_op(r_en, addr, $urandom, 1, 0, 0, 0, 0);
                6:          do_op(r_en, addr, $urandom, 0, 1, $urandom_range(0, 1), 0, 0);
                7:          do_op(r_en, addr, $urandom, 0, $urandom_range(0, 1), $urandom_range(0, 1), 1, 0);
                8:          do_op(r_en, addr, $urandom, 0, 0, 0, 0, 1);
                default:    do_op(r_en, addr, $urandom, 1'($urandom), 1'($urandom), $urandom_range(0, 1),
                                  1'($urandom), 1'($urandom));
            endcase
        end

        // Reset in the middle of the sweep; everything installed earlier must miss.
        reset_and_init(50);
        do_op(1, 32'h0001_5040, 32'h0, 0, 0, 0, 0, 0);
        chk("req042_miss_a", 32'(hit), 32'd0);
        do_op(1, mk_addr(3, 2, 1), 32'h0, 0, 0, 0, 0, 0);
        chk("req042_miss_b", 32'(hit), 32'd0);

        for (int n = 0; n < 30; n++) begin
            addr = mk_addr($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1));
            r_op = $urandom_range(0, 3);
            if (r_op == 0)      do_op(1, addr, $urandom, 0, 1, $urandom_range(0, 1), 1, 0);
            else if (r_op == 1) do_op(1, addr, $urandom, 1, 0, 0, 0, 0);
            else                do_op(1, addr, $urandom, 0, 0, 0, 0, 0);
        end

        do_op(0, 32'h0, 32'h0, 0, 0, 0, 0, 0);
        @(negedge clk);
        tb_kind = 0;
        repeat (3) @(negedge clk);
        if (exp_q.size() != 0) chk("spo_queue_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/cache_set.md
CACHE_SET -- requirements
Module: cache_set

Interface
REQ-001 Parameter WAYS, default 2, number of ways; power of two, 2..8.
REQ-002 Parameter LINES, default 128, sets per way; power of two.
REQ-003 Parameter WORDS_PER_BLOCK, default 32, 32-bit words per block; power of two.
REQ-004 Derived TAG_LENGTH = 32 - log2(LINES) - log2(WORDS_PER_BLOCK) - 2; not overridable.
REQ-005 clk  in  1  sole clock, rising edge.
REQ-006 rst  in  1  reset, asynchronous, active-high.
REQ-007 en  in  1  access strobe; ignored while init_done=0.
REQ-008 a  in  32  byte address; offset a[log2(WPB)+1:2], index above it, tag in the remaining MSBs.
REQ-009 d  in  32  write/fill data.
REQ-010 we  in  1  CPU write; takes effect only on hit.
REQ-011 fill_we  in  1  write d into way fill_way at a, regardless of hit.
REQ-012 fill_way  in  log2(WAYS)  target way for fill_we/tag_we.
REQ-013 tag_we  in  1  install tag of a into fill_way at index; sets valid, clears dirty.
REQ-014 inval  in  1  clear valid of all ways at index of a.
REQ-015 spo  out  32  read data of hit way.
REQ-016 hit  out  1  tag of a matches a valid way at index (combinational).
REQ-017 hit_way  out  log2(WAYS)  matching way; 0 when hit=0.
REQ-018 victim_way, victim_tag, victim_dirty  out  log2(WAYS)/TAG_LENGTH/1  replacement candidate at index (combinational).
REQ-019 init_done  out  1  set-up sweep complete.

Function
REQ-020 Tags, valid, dirty and per-set round-robin pointer SHALL be distributed RAM, read combinationally from index.
REQ-021 spo SHALL present the word at {index,offset} of hit_way exactly one cycle after en with hit=1; holds previous value otherwise.
REQ-022 en&we&hit SHALL write d into hit_way and set that line's dirty bit in the same edge.
REQ-023 en&fill_we SHALL write d into fill_way; dirty unchanged.
REQ-024 en&tag_we SHALL write tag, valid=1, dirty=0 for fill_way, and advance the set's pointer by 1 modulo WAYS (wraps WAYS-1 -> 0).
REQ-025 victim_way SHALL be the first invalid way (lowest number) at index if any, else the set's pointer.
REQ-026 Two or more ways matching (illegal) SHALL resolve to the lowest-numbered way.
REQ-027 Simultaneous inval and tag_we at same index: tag_we wins for fill_way, other ways invalidated.
REQ-028 Simultaneous we-hit and tag_we to same way/index: tag_we wins, dirty ends 0.
REQ-029 State machine INIT -> READY; INIT sweeps index 0..LINES-1 one per cycle clearing valid, dirty, pointer; moves to READY after index LINES-1; READY terminal until reset.
REQ-030 During INIT hit=0 and all writes SHALL be suppressed.

Reset
REQ-031 rst asserted at any time, including mid-sweep or mid-write, SHALL force INIT, sweep counter 0, init_done=0, spo=0.
REQ-032 init_done SHALL rise exactly LINES cycles after rst deassertion.
REQ-033 Data RAM contents are not reset; valid=0 makes them unreachable.

Configuration
REQ-034 Macro CACHE_SET_DIRTY_EN: defined -> dirty bits stored and victim_dirty driven per REQ-022/024; undefined -> no dirty storage, victim_dirty tied 0 (write-through use).

Structure
REQ-035 Package cache_pkg SHALL hold the index/offset/tag width functions and the INIT/READY state encoding.
REQ-036 Data storage SHALL instantiate the existing simple_ram once per way (generate loop), WIDTH 32, depth LINES*WORDS_PER_BLOCK.

Verification
REQ-037 Release rst, count cycles -> init_done=1 after exactly 128; en ignored before.
REQ-038 tag_we way1 a=0x0000_1040, fill d=0xDEADBEEF; read a -> hit=1, hit_way=1, spo=0xDEADBEEF next cycle.
REQ-039 Write 0x12345678 hit to a=0x0000_1040 -> victim_dirty=1 when way1 is victim (DIRTY_EN); 0 without macro.
REQ-040 Fill both ways of index 2, then three tag_we -> victim_way sequence 0,1,0 (pointer wrap).
REQ-041 inval on a=0x0000_1040 -> hit=0, victim_way=0 (first invalid).
REQ-042 Assert rst mid-sweep at cycle 50 -> init_done stays 0 for 128 further cycles, all prior tags miss.
